// File: rtl/nebula_plic_pkg.sv
// Shared types and constants for the nebula_plic interrupt controller.
package nebula_plic_pkg;

    typedef enum logic [1:0] {
        GW_IDLE = 2'd0,
        GW_PEND = 2'd1,
        GW_INFL = 2'd2
    } gw_state_e;

    localparam int unsigned ID_NONE = 0;

endpackage

// File: rtl/nebula_plic_gateway.sv
// Per-source gateway: IDLE/PEND/INFL tracking with edge detect and one
// deferred-edge bit so an edge seen while busy is replayed exactly once.
module nebula_plic_gateway
    import nebula_plic_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_irq,
    input  logic i_edge,
    input  logic i_claim,
    input  logic i_complete,
    output logic o_pending
);

    gw_state_e r_state;
    gw_state_e w_state_nxt;
    logic      r_defer;
    logic      w_defer_nxt;
    logic      r_prev;
    logic      w_rise;

    assign w_rise    = i_edge & i_irq & ~r_prev;
    assign o_pending = (r_state == GW_PEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= GW_IDLE;
            r_defer <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_defer <= w_defer_nxt;
            r_prev  <= i_irq;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_defer_nxt = r_defer;
        case (r_state)
            GW_IDLE: begin
                if (i_edge ? w_rise : i_irq) w_state_nxt = GW_PEND;
            end
            GW_PEND: begin
                if (i_claim) w_state_nxt = GW_INFL;
                if (w_rise)  w_defer_nxt = 1'b1;
            end
            GW_INFL: begin
                if (w_rise) w_defer_nxt = 1'b1;
                // An edge landing on the completing cycle is folded into the replay.
                if (i_complete) begin
                    w_state_nxt = (r_defer || w_rise) ? GW_PEND : GW_IDLE;
                    w_defer_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = GW_IDLE;
                w_defer_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/nebula_plic.sv
// Platform-level interrupt controller: per-source gateways, per-hart
// priority arbitration, registered interrupt and claim response outputs.
module nebula_plic
    import nebula_plic_pkg::*;
#(
    parameter int NUM_SOURCES = 64,
    parameter int NUM_HARTS   = 4,
    parameter int PRIO_W      = 3,
    parameter int ID_W        = $clog2(NUM_SOURCES)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_SOURCES-1:0]                 irq_src,
    input  logic [NUM_SOURCES-1:0]                 src_edge,
    input  logic [NUM_SOURCES-1:0][PRIO_W-1:0]     src_prio,
    input  logic [NUM_HARTS-1:0][NUM_SOURCES-1:0]  hart_en,
    input  logic [NUM_HARTS-1:0][PRIO_W-1:0]       hart_thresh,
    output logic [NUM_HARTS-1:0]                   irq_out,
    input  logic [NUM_HARTS-1:0]                   claim_req,
    output logic [NUM_HARTS-1:0][ID_W-1:0]         claim_id,
    output logic [NUM_HARTS-1:0]                   claim_vld,
    input  logic [NUM_HARTS-1:0]                   complete_req,
    input  logic [NUM_HARTS-1:0][ID_W-1:0]         complete_id,
    output logic [NUM_SOURCES-1:0]                 pending_o
);

    logic [NUM_SOURCES-1:0]           w_pending;
    logic [NUM_SOURCES-1:0]           w_taken;
    logic [NUM_SOURCES-1:0]           w_cmpl;
    logic [NUM_HARTS-1:0]             w_any;
    logic [NUM_HARTS-1:0][ID_W-1:0]   w_win;
    logic [PRIO_W-1:0]                w_best;
    logic                             w_elig;
    logic                             w_unused;

    logic [NUM_HARTS-1:0]             r_irq;
    logic [NUM_HARTS-1:0]             r_claim_vld;
    logic [NUM_HARTS-1:0][ID_W-1:0]   r_claim_id;

    assign w_pending[0] = 1'b0;

    for (genvar gi = 1; gi < NUM_SOURCES; gi++) begin : g_gw
        nebula_plic_gateway u_gw (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_irq      (irq_src[gi]),
            .i_edge     (src_edge[gi]),
            .i_claim    (w_taken[gi]),
            .i_complete (w_cmpl[gi]),
            .o_pending  (w_pending[gi])
        );
    end

    // Harts are served in index order; a source granted to a lower hart this
    // cycle is masked out for the higher ones.
    always_comb begin
        w_taken = '0;
        w_any   = '0;
        w_win   = '0;
        w_best  = '0;
        w_elig  = 1'b0;
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            w_best = '0;
            for (int unsigned i = 1; i < NUM_SOURCES; i++) begin
                w_elig = w_pending[i] && hart_en[h][i] && (src_prio[i] > hart_thresh[h]);
                if (w_elig) w_any[h] = 1'b1;
                if (w_elig && !w_taken[i] &&
                    (w_win[h] == ID_W'(ID_NONE) || src_prio[i] > w_best)) begin
                    w_win[h] = ID_W'(i);
                    w_best   = src_prio[i];
                end
            end
            if (claim_req[h] && w_win[h] != ID_W'(ID_NONE)) w_taken[w_win[h]] = 1'b1;
        end
    end

    always_comb begin
        w_cmpl = '0;
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            for (int unsigned i = 1; i < NUM_SOURCES; i++) begin
                if (complete_req[h] && complete_id[h] == ID_W'(i)) w_cmpl[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_unused = irq_src[0] ^ src_edge[0] ^ (^src_prio[0]);
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            w_unused = w_unused ^ hart_en[h][0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq       <= '0;
            r_claim_vld <= '0;
            r_claim_id  <= '0;
        end else begin
            r_irq       <= w_any;
            r_claim_vld <= claim_req;
            for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                r_claim_id[h] <= claim_req[h] ? w_win[h] : ID_W'(ID_NONE);
            end
        end
    end

    assign irq_out   = r_irq;
    assign claim_vld = r_claim_vld;
    assign claim_id  = r_claim_id;
    assign pending_o = w_pending;

endmodule

// File: tb/tb_nebula_plic.sv
// Scoreboard bench for nebula_plic: claim responses are queued at request
// time and matched when claim_vld appears; other outputs checked inline.
module tb_nebula_plic;

    localparam int NS = 64;
    localparam int NH = 4;
    localparam int PW = 3;
    localparam int IW = 6;

    logic                        clk;
    logic                        rst_n;
    logic [NS-1:0]               irq_src;
    logic [NS-1:0]               src_edge;
    logic [NS-1:0][PW-1:0]       src_prio;
    logic [NH-1:0][NS-1:0]       hart_en;
    logic [NH-1:0][PW-1:0]       hart_thresh;
    logic [NH-1:0]               irq_out;
    logic [NH-1:0]               claim_req;
    logic [NH-1:0][IW-1:0]       claim_id;
    logic [NH-1:0]               claim_vld;
    logic [NH-1:0]               complete_req;
    logic [NH-1:0][IW-1:0]       complete_id;
    logic [NS-1:0]               pending_o;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    nebula_plic #(
        .NUM_SOURCES (NS),
        .NUM_HARTS   (NH),
        .PRIO_W      (PW),
        .ID_W        (IW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_src      (irq_src),
        .src_edge     (src_edge),
        .src_prio     (src_prio),
        .hart_en      (hart_en),
        .hart_thresh  (hart_thresh),
        .irq_out      (irq_out),
        .claim_req    (claim_req),
        .claim_id     (claim_id),
        .claim_vld    (claim_vld),
        .complete_req (complete_req),
        .complete_id  (complete_id),
        .pending_o    (pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected claim responses are encoded as hart*256 + id, in hart order.
    always @(negedge clk) begin
        for (int h = 0; h < NH; h++) begin
            if (claim_vld[h]) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_claim", h * 256 + int'(claim_id[h]), -1);
                end else begin
                    check_val("claim_resp", h * 256 + int'(claim_id[h]), exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic do_claim(input int h, input int exp_id);
        claim_req[h] = 1'b1;
        exp_q.push_back(h * 256 + exp_id);
        tick();
        claim_req[h] = 1'b0;
    endtask

    task automatic do_complete(input int h, input int id);
        complete_req[h] = 1'b1;
        complete_id[h]  = IW'(id);
        tick();
        complete_req[h] = 1'b0;
        complete_id[h]  = '0;
    endtask

    task automatic set_src(input int id, input int prio, input logic edg);
        src_prio[id] = PW'(prio);
        src_edge[id] = edg;
    endtask

    initial begin
        rst_n        = 1'b0;
        irq_src      = '0;
        src_edge     = '0;
        src_prio     = '0;
        hart_en      = '0;
        hart_thresh  = '0;
        claim_req    = '0;
        complete_req = '0;
        complete_id  = '0;

        // Level source 5 held high through reset must not show up yet
        set_src(5, 3, 1'b0);
        hart_en[0][5]  = 1'b1;
        hart_thresh[0] = PW'(1);
        irq_src[5]     = 1'b1;
        ticks(3);
        check_val("rst_pending", int'(pending_o), 0);
        check_val("rst_irq_out", int'(irq_out), 0);
        check_val("rst_claim_vld", int'(claim_vld), 0);
        check_val("rst_claim_id", int'(claim_id), 0);

        rst_n = 1'b1;
        tick();
        check_val("l5_pending", int'(pending_o[5]), 1);
        check_val("l5_irq_pre", int'(irq_out[0]), 0);
        tick();
        check_val("l5_irq", int'(irq_out[0]), 1);
        do_claim(0, 5);
        tick();
        check_val("l5_irq_infl", int'(irq_out[0]), 0);
        check_val("l5_pend_infl", int'(pending_o[5]), 0);
        ticks(2);
        check_val("l5_irq_infl2", int'(irq_out[0]), 0);
        do_complete(0, 5);
        tick();
        check_val("l5_irq_gap", int'(irq_out[0]), 0);
        tick();
        check_val("l5_irq_reassert", int'(irq_out[0]), 1);
        irq_src[5] = 1'b0;
        do_claim(0, 5);
        do_complete(0, 5);
        hart_en[0][5] = 1'b0;
        ticks(2);
        check_val("l5_idle", int'(pending_o[5]), 0);

        // Priority ordering with tie-break on lowest ID
        set_src(3, 4, 1'b0);
        set_src(7, 4, 1'b0);
        set_src(9, 2, 1'b0);
        hart_en[0][3] = 1'b1; hart_en[0][7] = 1'b1; hart_en[0][9] = 1'b1;
        irq_src[3] = 1'b1; irq_src[7] = 1'b1; irq_src[9] = 1'b1;
        ticks(2);
        do_claim(0, 3);
        do_claim(0, 7);
        do_claim(0, 9);
        do_claim(0, 0);
        irq_src[3] = 1'b0; irq_src[7] = 1'b0; irq_src[9] = 1'b0;
        do_complete(0, 3);
        do_complete(0, 7);
        do_complete(0, 9);
        hart_en[0] = '0;
        hart_thresh[0] = '0;

        // Edge source 12: three edges while in flight replay exactly once
        set_src(12, 1, 1'b1);
        hart_en[0][12] = 1'b1;
        irq_src[12] = 1'b1;
        tick();
        check_val("e12_pending", int'(pending_o[12]), 1);
        do_claim(0, 12);
        for (int k = 0; k < 3; k++) begin
            irq_src[12] = 1'b0;
            tick();
            irq_src[12] = 1'b1;
            tick();
        end
        check_val("e12_infl_nopend", int'(pending_o[12]), 0);
        do_complete(0, 12);
        check_val("e12_replay", int'(pending_o[12]), 1);
        do_claim(0, 12);
        do_claim(0, 0);
        do_complete(0, 12);
        tick();
        check_val("e12_done", int'(pending_o[12]), 0);
        hart_en[0] = '0;

        // Threshold is strict: prio 2 vs thresh 2 stays quiet
        set_src(4, 2, 1'b0);
        hart_en[1][4]  = 1'b1;
        hart_thresh[1] = PW'(2);
        irq_src[4]     = 1'b1;
        ticks(3);
        check_val("t4_pending", int'(pending_o[4]), 1);
        check_val("t4_irq_masked", int'(irq_out[1]), 0);
        hart_thresh[1] = PW'(1);
        tick();
        check_val("t4_irq", int'(irq_out[1]), 1);
        irq_src[4] = 1'b0;
        do_claim(1, 4);
        do_complete(1, 4);
        hart_en[1] = '0;

        // Simultaneous claims; complete of a merely pending ID is ignored
        set_src(6, 5, 1'b0);
        set_src(8, 1, 1'b0);
        hart_en[0][6] = 1'b1; hart_en[0][8] = 1'b1;
        hart_en[2][6] = 1'b1; hart_en[2][8] = 1'b1;
        hart_thresh[0] = '0; hart_thresh[2] = '0;
        irq_src[6] = 1'b1; irq_src[8] = 1'b1;
        ticks(2);
        do_complete(0, 8);
        check_val("s8_still_pend", int'(pending_o[8]), 1);
        claim_req[0] = 1'b1;
        claim_req[2] = 1'b1;
        exp_q.push_back(0 * 256 + 6);
        exp_q.push_back(2 * 256 + 8);
        tick();
        claim_req = '0;
        check_val("s_both_infl", int'(pending_o[8:6]), 0);
        do_claim(1, 0);
        irq_src[6] = 1'b0; irq_src[8] = 1'b0;
        // Claim and complete of the same source in one cycle
        irq_src[6] = 1'b1;
        do_complete(0, 6);
        tick();
        claim_req[0]    = 1'b1;
        complete_req[2] = 1'b1;
        complete_id[2]  = IW'(6);
        exp_q.push_back(0 * 256 + 6);
        tick();
        claim_req = '0; complete_req = '0; complete_id = '0;
        check_val("cc_infl", int'(pending_o[6]), 0);
        irq_src[6] = 1'b0;
        do_complete(0, 6);
        do_complete(2, 8);
        tick();
        check_val("s_clean", int'(pending_o), 0);
        hart_en = '0;

        // Reset mid-flight, level line still high re-pends right after release
        set_src(10, 3, 1'b0);
        hart_en[0][10] = 1'b1;
        irq_src[10] = 1'b1;
        ticks(2);
        check_val("r10_irq", int'(irq_out[0]), 1);
        do_claim(0, 10);
        tick();
        check_val("r10_infl", int'(pending_o[10]), 0);
        claim_req[0] = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("r10_rst_irq", int'(irq_out), 0);
        check_val("r10_rst_pend", int'(pending_o), 0);
        check_val("r10_rst_vld", int'(claim_vld), 0);
        check_val("r10_rst_id", int'(claim_id), 0);
        tick();
        claim_req = '0;
        rst_n = 1'b1;
        tick();
        check_val("r10_repend", int'(pending_o[10]), 1);
        tick();
        check_val("r10_irq_again", int'(irq_out[0]), 1);
        do_claim(0, 10);
        tick();

        check_val("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
